// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_out_if.sv
// rtl/uart_tx_out_if.sv - byte handshake between the FIFO-drain controller and the UART output stage
interface uart_tx_out_if;
  logic [7:0] out_data;
  logic       out_start;
  logic       out_finish;

  modport master (output out_data, output out_start, input out_finish);
  modport slave  (input out_data, input out_start, output out_finish);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period down-counter; bit_done pulses as the count passes 0
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart wins over the terminal count so a fresh bit always gets a full period.
  assign bit_done = enable && !restart && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (restart || (cnt_q == '0)) begin
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_out.sv
// rtl/uart_tx_out.sv - serialises one byte per out_start edge into a UART frame on tx
module uart_tx_out
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  uart_tx_out_if.slave   up,
  output logic           tx,
  output logic [2:0]     tx_bit_idx
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_out: CLKS_PER_BIT out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_out: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_out: PARITY must be 0, 1 or 2");
  end

  localparam bit HAS_PAR  = (PARITY != PAR_NONE);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       tx_q, tx_d;
  logic       fin_q, fin_d;
  logic       start_q, start_d;
  logic       accept;
  logic       bit_done;

  // Only a fresh rising edge in IDLE starts a frame; edges seen while busy are lost.
  assign accept  = enable && (state_q == IDLE) && up.out_start && !start_q;
  assign start_d = enable ? up.out_start : start_q;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .restart  (accept),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      fin_q   <= 1'b1;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      fin_q   <= fin_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = START;
    end else if (bit_done) begin
      case (state_q)
        START:   state_d = DATA;
        DATA:    if (idx_q == 3'd7) state_d = HAS_PAR ? uart_pkg::PARITY : STOP;
        uart_pkg::PARITY: state_d = STOP;
        STOP:    if (!TWO_STOP || stop_q) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // tx is registered: each transition loads the level of the bit being entered.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    fin_d   = fin_q;
    if (accept) begin
      shift_d = up.out_data;
      par_d   = parity_bit(up.out_data, PARITY);
      idx_d   = 3'd0;
      stop_d  = 1'b0;
      tx_d    = 1'b0;
      fin_d   = 1'b0;
    end else if (bit_done) begin
      case (state_q)
        START: begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = 3'd0;
        end
        DATA: begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            tx_d  = HAS_PAR ? par_q : 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
        uart_pkg::PARITY: begin
          tx_d = 1'b1;
        end
        STOP: begin
          if (!TWO_STOP || stop_q) begin
            fin_d  = 1'b1;
            stop_d = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
        default: begin
          tx_d = tx_q;
        end
      endcase
    end
  end

  assign tx            = tx_q;
  assign tx_bit_idx    = idx_q;
  assign up.out_finish = fin_q;

endmodule
